// File: rtl/cart_mem_seq_if.sv
// rtl/cart_mem_seq_if.sv - access request/response and external SRAM bus bundle for cart_mem_seq
interface cart_mem_seq_if;
    logic        req;
    logic        we;
    logic [20:0] adr;
    logic        sel_rom;
    logic        sel_ram;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        done;
    logic        busy;
    logic        overrun;
    logic [21:0] mem_adr;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic        mem_we_n;
    logic [7:0]  mem_dout;
    logic        mem_dout_en;
    logic [7:0]  mem_din;

    // master: bus front end plus the SRAM device; slave: the sequencer
    modport master (
        output req, we, adr, sel_rom, sel_ram, wdata, mem_din,
        input  rdata, done, busy, overrun,
        input  mem_adr, mem_ce_n, mem_oe_n, mem_we_n, mem_dout, mem_dout_en
    );

    modport slave (
        input  req, we, adr, sel_rom, sel_ram, wdata, mem_din,
        output rdata, done, busy, overrun,
        output mem_adr, mem_ce_n, mem_oe_n, mem_we_n, mem_dout, mem_dout_en
    );
endinterface

// File: rtl/cart_mem_seq.sv
// rtl/cart_mem_seq.sv - MBC-to-async-SRAM access sequencer with wait states
// Optional last-read cache enabled by defining CART_MEM_LAST_READ_EN.
module cart_mem_seq #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [21:0] RAM_BASE    = 22'h200000
) (
    input logic          clk,
    input logic          reset_n,
    cart_mem_seq_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [21:0] mem_adr_q, mem_adr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        dout_en_q, dout_en_d;

    logic        sel_any;
    logic [21:0] map_adr;

`ifdef CART_MEM_LAST_READ_EN
    logic        cache_vld_q, cache_vld_d;
    logic [21:0] cache_adr_q, cache_adr_d;
    logic [7:0]  cache_dat_q, cache_dat_d;
    logic        cache_hit;
`endif

    always_comb begin
        sel_any = bus.sel_rom | bus.sel_ram;
        map_adr = bus.sel_rom ? {1'b0, bus.adr} : RAM_BASE + {7'd0, bus.adr[14:0]};
`ifdef CART_MEM_LAST_READ_EN
        cache_hit = cache_vld_q && (cache_adr_q == map_adr);
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        mem_adr_d  = mem_adr_q;
        mem_dout_d = mem_dout_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        overrun_d  = bus.req && (state_q != ST_IDLE);
`ifdef CART_MEM_LAST_READ_EN
        cache_vld_d = cache_vld_q;
        cache_adr_d = cache_adr_q;
        cache_dat_d = cache_dat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if (!bus.we && !sel_any) begin
                        done_d  = 1'b1;
                        rdata_d = 8'hFF;
                    end else if (bus.we && (bus.sel_rom || !sel_any)) begin
                        // MBC register write or stray write: never reaches SRAM
                        done_d = 1'b1;
`ifdef CART_MEM_LAST_READ_EN
                    end else if (!bus.we && cache_hit) begin
                        done_d  = 1'b1;
                        rdata_d = cache_dat_q;
`endif
                    end else begin
                        state_d   = ST_SETUP;
                        wr_d      = bus.we;
                        mem_adr_d = map_adr;
                        if (bus.we) begin
                            mem_dout_d = bus.wdata;
`ifdef CART_MEM_LAST_READ_EN
                            cache_vld_d = 1'b0;
`endif
                        end
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = WAIT_LAST;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    done_d  = 1'b1;
                    if (!wr_q) begin
                        rdata_d = bus.mem_din;
`ifdef CART_MEM_LAST_READ_EN
                        cache_vld_d = 1'b1;
                        cache_adr_d = mem_adr_q;
                        cache_dat_d = bus.mem_din;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // strobes follow the next state so every mem_* pin leaves a flop
        busy_d    = (state_d != ST_IDLE);
        ce_n_d    = (state_d == ST_IDLE);
        oe_n_d    = !((state_d == ST_ACCESS) && !wr_d);
        we_n_d    = !((state_d == ST_ACCESS) && wr_d);
        dout_en_d = (state_d != ST_IDLE) && wr_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            mem_adr_q  <= 22'd0;
            mem_dout_q <= 8'd0;
            rdata_q    <= 8'hFF;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            dout_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            mem_adr_q  <= mem_adr_d;
            mem_dout_q <= mem_dout_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            dout_en_q  <= dout_en_d;
        end
    end

`ifdef CART_MEM_LAST_READ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_vld_q <= 1'b0;
            cache_adr_q <= 22'd0;
            cache_dat_q <= 8'd0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_adr_q <= cache_adr_d;
            cache_dat_q <= cache_dat_d;
        end
    end
`endif

    assign bus.rdata       = rdata_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
    assign bus.mem_adr     = mem_adr_q;
    assign bus.mem_ce_n    = ce_n_q;
    assign bus.mem_oe_n    = oe_n_q;
    assign bus.mem_we_n    = we_n_q;
    assign bus.mem_dout    = mem_dout_q;
    assign bus.mem_dout_en = dout_en_q;

endmodule

// File: tb/tb_cart_mem_seq.sv
// tb/tb_cart_mem_seq.sv - scoreboard bench for cart_mem_seq with SRAM model and reference model
module tb_cart_mem_seq;

    localparam int W = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cart_mem_seq_if bus();

    cart_mem_seq #(.WAIT_CYCLES(W), .RAM_BASE(22'h200000)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        int         issue;
        int         lat;
        logic [7:0] rdata;
        int         n_oe;
        int         n_we;
        int         n_en;
        logic [21:0] adr;
        logic [7:0] dout;
    } exp_t;

    exp_t exp_q[$];
    int   ovr_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   free_cyc = 0;
    int   busy_lo = 0;
    int   busy_hi = -1;
    int   last_iss = 0;
    bit   last_full = 0;
    logic [7:0] sram [logic [21:0]];
    logic [7:0] refm [logic [21:0]];
    logic [7:0] last_rd = 8'hFF;
    bit   cache_v = 0;
    logic [21:0] cache_a = 22'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] dflt(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [21:0] a);
        return refm.exists(a) ? refm[a] : dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        bus.we      = 1'($urandom);
        bus.adr     = 21'($urandom);
        bus.sel_rom = 1'($urandom);
        bus.sel_ram = 1'($urandom);
        bus.wdata   = 8'($urandom);
    endtask

    task automatic issue(input logic w, input logic [20:0] a, input logic r, input logic m,
                         input logic [7:0] d);
        exp_t e;
        logic [21:0] ma;
        bit full;
        while (cyc < free_cyc) step();
        ma = r ? {1'b0, a} : 22'(2097152 + int'(a) % 32768);
        e.issue = cyc; e.n_oe = 0; e.n_we = 0; e.n_en = 0; e.adr = ma; e.dout = d;
        full = 0;
        if (!w) begin
            if (!r && !m) last_rd = 8'hFF;
`ifdef CART_MEM_LAST_READ_EN
            else if (cache_v && cache_a == ma) last_rd = ref_rd(ma);
`endif
            else begin
                full = 1; last_rd = ref_rd(ma); e.n_oe = W; cache_v = 1; cache_a = ma;
            end
        end else if (m && !r) begin
            full = 1; refm[ma] = d; e.n_we = W; e.n_en = W + 2; cache_v = 0;
        end
        e.rdata = last_rd;
        e.lat = full ? W + 2 : 1;
        if (full) begin
            busy_lo = cyc + 1; busy_hi = cyc + W + 2; free_cyc = cyc + W + 3;
        end else begin
            free_cyc = cyc + 1;
        end
        last_iss = cyc; last_full = full;
        exp_q.push_back(e);
        bus.req = 1'b1; bus.we = w; bus.adr = a; bus.sel_rom = r; bus.sel_ram = m; bus.wdata = d;
        step();
        bus.req = 1'b0;
        scramble();
    endtask

    // request arriving k cycles into a full access must be ignored and flagged
    task automatic poke(input int k);
        while (cyc < last_iss + k) step();
        scramble();
        bus.req = 1'b1;
        ovr_q.push_back(cyc + 1);
        step();
        bus.req = 1'b0;
    endtask

    logic [21:0] prev_adr, seen_adr;
    logic [7:0]  prev_dout, seen_dout;
    int n_oe = 0, n_we = 0, n_en = 0;

    always @(negedge clk) begin
        exp_t e;
        bit ovr_now;
        if (!reset_n) begin
            n_oe = 0; n_we = 0; n_en = 0;
        end else begin
            chk("strobe_excl", {31'd0, bus.mem_oe_n | bus.mem_we_n}, 1);
            chk("busy", {31'd0, bus.busy}, {31'd0, (cyc >= busy_lo && cyc <= busy_hi)});
            ovr_now = (ovr_q.size() > 0 && ovr_q[0] == cyc);
            if (ovr_now) void'(ovr_q.pop_front());
            chk("overrun", {31'd0, bus.overrun}, {31'd0, ovr_now});
            if (!bus.mem_oe_n) begin n_oe++; seen_adr = bus.mem_adr; end
            if (!bus.mem_we_n) begin
                n_we++; seen_adr = bus.mem_adr; seen_dout = bus.mem_dout;
                chk("we_adr_stable", bus.mem_adr, prev_adr);
                chk("we_dout_stable", bus.mem_dout, prev_dout);
            end
            if (bus.mem_dout_en) n_en++;
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", {31'd0, bus.done}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - e.issue, e.lat);
                    chk("rdata", bus.rdata, e.rdata);
                    chk("oe_cycles", n_oe, e.n_oe);
                    chk("we_cycles", n_we, e.n_we);
                    chk("dout_en_cycles", n_en, e.n_en);
                    if (e.n_oe != 0 || e.n_we != 0) chk("mem_adr", seen_adr, e.adr);
                    if (e.n_we != 0) chk("mem_dout", seen_dout, e.dout);
                end
                n_oe = 0; n_we = 0; n_en = 0;
            end
        end
        prev_adr = bus.mem_adr;
        prev_dout = bus.mem_dout;
        if (!bus.mem_we_n) sram[bus.mem_adr] = bus.mem_dout;
        bus.mem_din = sram.exists(bus.mem_adr) ? sram[bus.mem_adr] : dflt(bus.mem_adr);
    end

    initial begin
        logic [20:0] pool [4];
        logic [20:0] a;
        logic [1:0]  s;
        bus.req = 1'b0;
        scramble();
        sram[22'h004123] = 8'h5A;
        refm[22'h004123] = 8'h5A;
        repeat (3) step();
        chk("rst_rdata", bus.rdata, 8'hFF);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_overrun", {31'd0, bus.overrun}, 0);
        chk("rst_strobes", {29'd0, bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, 3'b111);
        chk("rst_dout_en", {31'd0, bus.mem_dout_en}, 0);
        chk("rst_mem_adr", bus.mem_adr, 0);
        chk("rst_mem_dout", bus.mem_dout, 0);
        reset_n = 1'b1;
        free_cyc = cyc + 1;

        issue(0, 21'h04123, 1, 0, 8'h00);
        issue(1, 21'h01ABC, 0, 1, 8'hC3);
        issue(1, 21'h00777, 1, 0, 8'h11);
        issue(0, 21'h12345, 0, 0, 8'h00);
        issue(0, 21'h1F0F0, 1, 0, 8'h00);
        poke(2);
        issue(0, 21'h00042, 1, 1, 8'h00);
        poke(W + 2);

        // reset during the second ACCESS cycle of a RAM write
        issue(1, 21'h007FFF, 0, 1, 8'hA5);
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("midrst_strobes", {29'd0, bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, 3'b111);
        chk("midrst_dout_en", {31'd0, bus.mem_dout_en}, 0);
        chk("midrst_done", {31'd0, bus.done}, 0);
        chk("midrst_rdata", bus.rdata, 8'hFF);
        exp_q.delete();
        ovr_q.delete();
        busy_hi = -1;
        cache_v = 0;
        last_rd = 8'hFF;
        step();
        step();
        reset_n = 1'b1;
        free_cyc = cyc + 1;
        issue(0, 21'h0ABCD, 1, 0, 8'h00);

`ifdef CART_MEM_LAST_READ_EN
        issue(0, 21'h00100, 1, 0, 8'h00);
        issue(0, 21'h00100, 1, 0, 8'h00);
        issue(1, 21'h00200, 0, 1, 8'h77);
        issue(0, 21'h00100, 1, 0, 8'h00);
`endif

        for (int i = 0; i < 4; i++) pool[i] = 21'($urandom);
        for (int i = 0; i < 300; i++) begin
            a = ($urandom % 2 == 0) ? pool[$urandom % 4] : 21'($urandom);
            if (a[14:0] == 15'h7FFF) a[0] = 1'b0;
            s = 2'($urandom);
            issue(1'($urandom), a, s[0], s[1], 8'($urandom));
            if (last_full && ($urandom % 4 == 0)) poke(1 + int'($urandom % (W + 2)));
        end

        for (int i = 0; i < 50 && (exp_q.size() > 0 || ovr_q.size() > 0); i++) step();
        chk("drain_done", exp_q.size(), 0);
        chk("drain_overrun", ovr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cart_mem_seq.md
# cart_mem_seq

Sequencer between the cartridge MBC and the board's external asynchronous SRAM, which holds the 2 MiB ROM image and the 32 KiB cartridge RAM. It takes one translated access: the MBC's 21-bit output address, its ROM/RAM selects, and a request strobe from the bus front end. It then runs a fixed-timing SRAM read or write cycle with configurable wait states and returns latched read data plus a completion pulse.

## Interface
Parameters:
- WAIT_CYCLES, 2: cycles with OE_n/WE_n asserted; legal 1..15.
- RAM_BASE, 22'h200000: external address where cartridge RAM starts.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  one-cycle access request.
- we  in  1  1 = write, 0 = read; sampled with req.
- adr  in  21  translated address from the MBC.
- sel_rom  in  1  ROM region select.
- sel_ram  in  1  RAM region select.
- wdata  in  8  write data; sampled with req.
- rdata  out  8  read result; holds until the next completed read.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after acceptance until done.
- overrun  out  1  one-cycle pulse when req arrives while busy.
- mem_adr  out  22  SRAM address.
- mem_ce_n, mem_oe_n, mem_we_n  out  1 each  SRAM strobes, active-low.
- mem_dout  out  8  SRAM write data.
- mem_dout_en  out  1  drive enable for the SRAM data pads.
- mem_din  in  8  SRAM read data.

## Operation
- The request (adr, we, wdata, selects) is captured on the accept edge. Inputs are don't-care afterwards.
- Address map:
  - sel_rom: mem_adr = {1'b0, adr}.
  - sel_ram: mem_adr = RAM_BASE + adr[14:0].
  - If both selects are high, sel_rom wins.
- Null accesses: done pulses the next cycle with no SRAM cycle. They are:
  - A read with no select; rdata becomes 8'hFF.
  - A write with sel_rom; these are MBC register writes and must never reach SRAM.
  - A write with no select.
- All other accesses run the state machine IDLE → SETUP → ACCESS → HOLD → IDLE:
  - IDLE: all strobes high; mem_dout_en = 0.
  - SETUP (1 cycle): mem_adr valid; ce_n = 0. For a write, mem_dout = wdata and mem_dout_en = 1.
  - ACCESS (WAIT_CYCLES cycles): a 4-bit counter decrements to 0. A read asserts oe_n = 0; a write asserts we_n = 0.
  - HOLD (1 cycle): oe_n/we_n high; ce_n, address and data held. Read data is captured from mem_din on the edge that leaves the last ACCESS cycle. done = 1.
- req while busy (including the HOLD cycle): the request is ignored, overrun pulses, and the in-flight access is unaffected.
- req in the cycle done is high from a null access: accepted normally.
- oe_n and we_n are never low in the same cycle.
- we_n is never low while the address or data is changing.

## Timing
- Reset values: rdata = 8'hFF; done = busy = overrun = 0; ce_n = oe_n = we_n = 1; mem_dout_en = 0; mem_adr = 0; mem_dout = 0; state IDLE.
- Full access: req at edge N → done high in cycle N+WAIT_CYCLES+2 → next req accepted at edge N+WAIT_CYCLES+3.
- Null access: done in cycle N+1; busy stays 0.
- reset_n low mid-access: all strobes go high and mem_dout_en goes 0 asynchronously, with no done pulse. A partially-written SRAM byte is acceptable.
- All outputs are registered; no combinational path from req to the mem_* outputs.

## Configuration
- CART_MEM_LAST_READ_EN:
  - Defined: a one-entry cache holds the mem_adr and data of the last completed SRAM read plus a valid bit.
  - A read hitting the cached address completes with done in cycle N+1, rdata = cached data, and no SRAM cycle.
  - Any accepted SRAM write, and reset, clears the valid bit.
  - Undefined: every read performs a full SRAM cycle, and no cache registers exist.

## Test plan
- ROM read, WAIT_CYCLES=2: adr=21'h04123, sel_rom, mem_din=8'h5A → mem_adr=22'h004123; oe_n low for exactly 2 cycles; done at N+4; rdata=8'h5A.
- RAM write: adr=21'h01ABC, sel_ram, wdata=8'hC3 → mem_adr=22'h201ABC; mem_dout_en high SETUP through HOLD; we_n low 2 cycles; done at N+4.
- ROM write: sel_rom, we=1 → done at N+1; ce_n, we_n and mem_dout_en never change.
- Unselected read: no select → done at N+1, rdata=8'hFF; a second req during an active ROM read → overrun pulse, first read completes unchanged.
- Reset mid-ACCESS on a write → strobes high the same cycle; after release a read completes normally with rdata from mem_din.
- With CART_MEM_LAST_READ_EN: two reads of ROM 21'h00100 → second done at N+1 without oe_n; then a RAM write and a reread → full cycle with oe_n asserted.
